// File: rtl/riscv_fetch_unit.sv
// Instruction fetch front end: PC, credit-limited imem requests, registered instruction FIFO, redirect flush.
// Optional macro FETCH_MISALIGN_CHECK_EN: a misaligned redirect target enters a terminal FAULT state.
`timescale 1ns/1ps
module riscv_fetch_unit #(
  parameter int                     WORD_LENGTH = 32,
  parameter logic [WORD_LENGTH-1:0] RESET_PC    = '0,
  parameter int                     FIFO_DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [WORD_LENGTH-1:0] imem_addr,
  input  logic                   imem_rsp_valid,
  input  logic [WORD_LENGTH-1:0] imem_rsp_data,
  output logic                   inst_valid,
  output logic [WORD_LENGTH-1:0] inst,
  output logic [WORD_LENGTH-1:0] inst_pc,
  input  logic                   inst_ready,
  input  logic                   redirect_valid,
  input  logic [WORD_LENGTH-1:0] redirect_pc,
  output logic                   fetch_fault
);
  // Handshakes: a transfer happens on a rising edge where valid && ready; the request
  // side holds valid/addr stable until accepted unless a redirect intervenes.

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [WORD_LENGTH-1:0] ALIGN_MASK = {{(WORD_LENGTH-2){1'b1}}, 2'b00};

  typedef enum logic {ST_FETCH = 1'b0, ST_FAULT = 1'b1} state_e;

  state_e                 state_q, state_d;
  logic [WORD_LENGTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [WORD_LENGTH-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]          outst_q, outst_d;
  logic [CW-1:0]          drop_q, drop_d;
  logic [CW-1:0]          count_q, count_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [WORD_LENGTH-1:0] data_q [FIFO_DEPTH];
  logic [WORD_LENGTH-1:0] pc_q   [FIFO_DEPTH];

  logic [WORD_LENGTH-1:0] redirect_tgt;
  logic [CW:0]            in_use;
  logic                   credit_ok;
  logic                   req_fire;
  logic                   rsp_keep;
  logic                   pop;
  logic                   fault_enter;

  assign redirect_tgt = redirect_pc & ALIGN_MASK;
  assign in_use       = {1'b0, outst_q} + {1'b0, count_q};
  assign credit_ok    = in_use < (CW+1)'(FIFO_DEPTH);
  assign req_fire     = imem_req_valid && imem_req_ready;
  assign pop          = inst_valid && inst_ready;
  assign rsp_keep     = imem_rsp_valid && (drop_q == '0) && (state_q == ST_FETCH) && !redirect_valid;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign fault_enter = redirect_valid && (state_q == ST_FETCH) && (redirect_pc[1:0] != 2'b00);
`else
  assign fault_enter = 1'b0;
`endif

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_FETCH;
    else        state_q <= state_d;
  end

  // FSM: next state (FAULT is terminal until reset)
  always_comb begin
    state_d = state_q;
    if (fault_enter) state_d = ST_FAULT;
  end

  // FSM: outputs
  always_comb begin
    imem_req_valid = rst_n && (state_q == ST_FETCH) && !redirect_valid && credit_ok;
    imem_addr      = fetch_pc_q;
    inst_valid     = (count_q != '0);
    inst           = inst_valid ? data_q[rd_ptr_q] : '0;
    inst_pc        = inst_valid ? pc_q[rd_ptr_q]   : '0;
    fetch_fault    = (state_q == ST_FAULT);
  end

  // Responses return in order and every stale one is dropped, so the PC of the next
  // kept response is simply the redirect target plus 4 per kept word.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    outst_d    = outst_q + CW'(req_fire) - CW'(imem_rsp_valid);
    drop_d     = drop_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    if (redirect_valid) begin
      drop_d   = outst_d;
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      if (state_q == ST_FETCH) begin
        fetch_pc_d = redirect_tgt;
        rsp_pc_d   = redirect_tgt;
      end
    end else begin
      if (imem_rsp_valid && (drop_q != '0)) drop_d = drop_q - CW'(1);
      if (req_fire) fetch_pc_d = fetch_pc_q + WORD_LENGTH'(4);
      if (rsp_keep) begin
        rsp_pc_d = rsp_pc_q + WORD_LENGTH'(4);
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(rsp_keep) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Storage needs no reset: entries are only visible while count_q covers them.
  always_ff @(posedge clk) begin
    if (rsp_keep) begin
      data_q[wr_ptr_q] <= imem_rsp_data;
      pc_q[wr_ptr_q]   <= rsp_pc_q;
    end
  end

endmodule
